// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and baud-rate helpers.
// Imported by the receiver, the transmitter and the synchronizer users.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_START = 2'b01,
    S_DATA  = 2'b10,
    S_STOP  = 2'b11
  } uart_state_e;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud_rate
  );
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Synchronous active-low reset loads RST_VAL into both stages.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: recovers start/data(LSB first)/stop frames from rx_serial.
// Samples each bit at its midpoint; rx_data only moves on a good stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE = 9600,
  parameter int CLK_FREQ  = 100_000_000,
  parameter int DATA_BITS = 8
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 rx_frame_err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(DATA_BITS) + 1;

  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic rx_s;

  uart_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk_i  (PCLK),
    .rst_ni (PRESETn),
    .d_i    (rx_serial),
    .q_o    (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 ferr_q, ferr_d;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    ferr_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        busy_d    = 1'b0;
        if (!rx_s) begin
          state_d = S_START;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (clk_cnt_q == HALF_END) begin
          clk_cnt_d = '0;
          // A start bit that is high again at its midpoint is noise.
          if (!rx_s) begin
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d = '0;
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          if (rx_s) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign rx_data      = data_q;
  assign rx_done      = done_q;
  assign rx_busy      = busy_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit, 8 data bits.
// Frames are driven by a behavioural transmitter task.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       PCLK;
  logic       PRESETn;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       rx_frame_err;

  int n_cmp;
  int n_err;
  int cyc;
  int done_cnt;
  int ferr_cnt;
  int both_cnt;
  int last_done_cyc;
  int frame_cyc;
  int busy_bad;

  uart_rx #(
    .BAUD_RATE (10),
    .CLK_FREQ  (160),
    .DATA_BITS (8)
  ) dut (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .rx_serial    (rx_serial),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  always @(negedge PCLK) begin
    if (rx_done) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
    if (rx_frame_err) ferr_cnt <= ferr_cnt + 1;
    if (rx_done && rx_frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tx_bit(input logic b);
    rx_serial = b;
    repeat (CPB) @(posedge PCLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    frame_cyc = cyc;
    tx_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (!rx_busy) busy_bad++;
      tx_bit(d[i]);
    end
    if (!rx_busy) busy_bad++;
    tx_bit(stop);
    rx_serial = 1'b1;
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  initial begin
    int d0;
    int f0;
    int lat;
    int t_first;
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    done_cnt = 0;
    ferr_cnt = 0;
    both_cnt = 0;
    last_done_cyc = 0;
    busy_bad = 0;
    rx_serial = 1'b1;
    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_data", 32'(rx_data), 32'h0);
    check("rst_done", 32'(rx_done), 32'h0);
    check("rst_busy", 32'(rx_busy), 32'h0);
    check("rst_ferr", 32'(rx_frame_err), 32'h0);
    PRESETn = 1'b1;
    idle(20);

    // 1: single good frame
    d0 = done_cnt;
    f0 = ferr_cnt;
    busy_bad = 0;
    send_frame(8'hA5, 1'b1);
    lat = last_done_cyc - frame_cyc;
    check("t1_data", 32'(rx_data), 32'hA5);
    check("t1_ndone", 32'(done_cnt - d0), 32'd1);
    check("t1_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("t1_busy", 32'(busy_bad), 32'd0);
    check("t1_lat", 32'(lat >= 154 && lat <= 156), 32'd1);
    check("t1_busy_end", 32'(rx_busy), 32'h0);
    idle(10);

    // 2: back-to-back frames, no idle gap
    d0 = done_cnt;
    send_frame(8'h00, 1'b1);
    t_first = last_done_cyc;
    check("t2_data0", 32'(rx_data), 32'h00);
    send_frame(8'hFF, 1'b1);
    check("t2_data1", 32'(rx_data), 32'hFF);
    check("t2_ndone", 32'(done_cnt - d0), 32'd2);
    check("t2_gap", 32'(last_done_cyc - t_first), 32'd160);
    idle(10);

    // 3: short low glitch
    d0 = done_cnt;
    f0 = ferr_cnt;
    rx_serial = 1'b0;
    repeat (4) @(posedge PCLK);
    #1;
    check("t3_busy_hi", 32'(rx_busy), 32'h1);
    idle(30);
    check("t3_busy_lo", 32'(rx_busy), 32'h0);
    check("t3_ndone", 32'(done_cnt - d0), 32'd0);
    check("t3_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("t3_data", 32'(rx_data), 32'hFF);

    // 4: framing error after a good frame
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b1);
    idle(5);
    send_frame(8'h81, 1'b0);
    idle(40);
    check("t4_data", 32'(rx_data), 32'h3C);
    check("t4_ndone", 32'(done_cnt - d0), 32'd1);
    check("t4_ferr", 32'(ferr_cnt - f0), 32'd1);

    // 5: reset in the middle of the data bits
    tx_bit(1'b0);
    tx_bit(1'b1);
    tx_bit(1'b0);
    tx_bit(1'b1);
    PRESETn = 1'b0;
    @(posedge PCLK);
    #1;
    check("t5_data", 32'(rx_data), 32'h0);
    check("t5_done", 32'(rx_done), 32'h0);
    check("t5_busy", 32'(rx_busy), 32'h0);
    check("t5_ferr", 32'(rx_frame_err), 32'h0);
    PRESETn = 1'b1;
    d0 = done_cnt;
    f0 = ferr_cnt;
    idle(200);
    check("t5_quiet", 32'(done_cnt - d0 + ferr_cnt - f0), 32'd0);
    send_frame(8'h96, 1'b1);
    idle(5);
    check("t5_data2", 32'(rx_data), 32'h96);
    check("t5_ndone", 32'(done_cnt - d0), 32'd1);

    // 6: every byte value through a behavioural transmitter
    d0 = done_cnt;
    f0 = ferr_cnt;
    for (int b = 0; b < 256; b++) begin
      send_frame(8'(b), 1'b1);
      check("t6_byte", 32'(rx_data), 32'(b));
    end
    idle(20);
    check("t6_ndone", 32'(done_cnt - d0), 32'd256);
    check("t6_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("excl", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
